// File: rtl/adder_ctrl.sv
// adder_ctrl
// Sequencing controller for the regfile-attached adder datapath. A rising
// edge on the regfile start bit latches operands R0/R1. The sum is then built
// serially, LANE_W bits per cycle, least significant slice first. The result
// is handed back to the regfile through a one-cycle write strobe. While the
// operation is in flight, o_busy holds off AXI4-Lite writes to the regfile.
//
// Ports:
//   ACLK                 clock, all state updates on the rising edge
//   ARSTn                asynchronous active-low reset
//   i_start              start bit from the regfile, triggers on its rising edge
//   i_r0, i_r1           operands A and B from the regfile
//   o_busr               result word, non-zero only during the write strobe
//   o_enable_ctrl_write  one-cycle write strobe to the regfile
//   o_carry              carry-out of the last completed addition
//   o_busy               operation in flight
//   o_done               one-cycle pulse, coincident with the write strobe

module adder_ctrl #(
  parameter int DATA_W = 32,
  parameter int LANE_W = 8
) (
  input  logic              ACLK,
  input  logic              ARSTn,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_r0,
  input  logic [DATA_W-1:0] i_r1,
  output logic [DATA_W-1:0] o_busr,
  output logic              o_enable_ctrl_write,
  output logic              o_carry,
  output logic              o_busy,
  output logic              o_done
);

  localparam int N     = DATA_W / LANE_W;
  // With a single slice the counter is never advanced past zero. It still
  // needs at least one bit to exist.
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    WRITE
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] opA_q, opA_d;
  logic [DATA_W-1:0] opB_q, opB_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              cy_q, cy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic              start_q;

  logic              startEvent;
  logic [LANE_W:0]   laneSum;

  // The start bit is level-held by the regfile, so only a low-to-high
  // transition starts an operation. start_q resets to 0. A bit that is
  // already high at reset release therefore counts as an edge.
  assign startEvent = i_start & ~start_q;

  // One lane of the ripple adder. The lane carry-out is kept in cy_q so
  // that it feeds the next, more significant slice on the following cycle.
  assign laneSum = {1'b0, opA_q[cnt_q*LANE_W +: LANE_W]}
                 + {1'b0, opB_q[cnt_q*LANE_W +: LANE_W]}
                 + {{LANE_W{1'b0}}, cy_q};

  // State and datapath registers. Reset drops any operation in flight
  // without issuing a write strobe.
  always_ff @(posedge ACLK or negedge ARSTn) begin
    if (!ARSTn) begin
      state_q <= IDLE;
      opA_q   <= '0;
      opB_q   <= '0;
      acc_q   <= '0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      opA_q   <= opA_d;
      opB_q   <= opB_d;
      acc_q   <= acc_d;
      cy_q    <= cy_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      start_q <= i_start;
    end
  end

  // Next-state logic. Operands are captured only in IDLE. This keeps the
  // sum immune to regfile changes mid-operation. Start edges seen in ADD or
  // WRITE are dropped, not queued.
  always_comb begin
    state_d = state_q;
    opA_d   = opA_q;
    opB_d   = opB_q;
    acc_d   = acc_q;
    cy_d    = cy_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;

    case (state_q)
      IDLE: begin
        if (startEvent) begin
          opA_d   = i_r0;
          opB_d   = i_r1;
          acc_d   = '0;
          cy_d    = 1'b0;
          cnt_d   = '0;
          carry_d = 1'b0;
          state_d = ADD;
        end
      end

      ADD: begin
        acc_d[cnt_q*LANE_W +: LANE_W] = laneSum[LANE_W-1:0];
        cy_d  = laneSum[LANE_W];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(N - 1)) begin
          state_d = WRITE;
        end
      end

      WRITE: begin
        // The carry becomes visible as the strobe ends. It then holds
        // until the next operation is started.
        carry_d = cy_q;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All outputs decode registered state only. The result bus is forced to
  // zero outside WRITE, so the regfile never samples a partial sum.
  assign o_busy              = (state_q != IDLE);
  assign o_enable_ctrl_write = (state_q == WRITE);
  assign o_done              = (state_q == WRITE);
  assign o_busr              = (state_q == WRITE) ? acc_q : '0;
  assign o_carry             = carry_q;

endmodule

// File: tb/tb_adder_ctrl.sv
// tb_adder_ctrl
// Directed bench for adder_ctrl. The main instance uses the default 8-bit
// lanes (N=4). Two further instances cover the single-slice (LANE_W=32) and
// bit-serial (LANE_W=1) extremes. Expected values are hand-computed constants.
// For the random sweep operands, a plain 33-bit reference add provides them.

module tb_adder_ctrl;

  logic        ACLK;
  logic        ARSTn;
  logic        i_start;
  logic [31:0] i_r0;
  logic [31:0] i_r1;
  logic [31:0] o_busr;
  logic        o_enable_ctrl_write;
  logic        o_carry;
  logic        o_busy;
  logic        o_done;

  logic        swStart;
  logic [31:0] swR0;
  logic [31:0] swR1;
  logic [31:0] busr32, busr1;
  logic        en32, en1, carry32, carry1, busy32, busy1, done32, done1;

  int compCount   = 0;
  int errCount    = 0;
  int strobeTotal = 0;
  int staleCount  = 0;
  int doneSkew    = 0;
  int timeouts    = 0;
  logic [31:0] lastResult = '0;

  adder_ctrl dut (
    .ACLK                (ACLK),
    .ARSTn               (ARSTn),
    .i_start             (i_start),
    .i_r0                (i_r0),
    .i_r1                (i_r1),
    .o_busr              (o_busr),
    .o_enable_ctrl_write (o_enable_ctrl_write),
    .o_carry             (o_carry),
    .o_busy              (o_busy),
    .o_done              (o_done)
  );

  adder_ctrl #(.DATA_W(32), .LANE_W(32)) dut32 (
    .ACLK                (ACLK),
    .ARSTn               (ARSTn),
    .i_start             (swStart),
    .i_r0                (swR0),
    .i_r1                (swR1),
    .o_busr              (busr32),
    .o_enable_ctrl_write (en32),
    .o_carry             (carry32),
    .o_busy              (busy32),
    .o_done              (done32)
  );

  adder_ctrl #(.DATA_W(32), .LANE_W(1)) dut1 (
    .ACLK                (ACLK),
    .ARSTn               (ARSTn),
    .i_start             (swStart),
    .i_r0                (swR0),
    .i_r1                (swR1),
    .o_busr              (busr1),
    .o_enable_ctrl_write (en1),
    .o_carry             (carry1),
    .o_busy              (busy1),
    .o_done              (done1)
  );

  // 100 MHz clock
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Watch the main instance on every falling edge. Record each write strobe
  // and its data. Flag any non-zero result bus outside a strobe, and any
  // done pulse that does not line up with the strobe.
  always @(negedge ACLK) begin
    if (o_enable_ctrl_write) begin
      strobeTotal++;
      lastResult = o_busr;
    end else if (o_busr !== 32'h0) begin
      staleCount++;
    end
    if (o_done !== o_enable_ctrl_write) doneSkew++;
    if (done32 !== en32 || done1 !== en1) doneSkew++;
  end

  // Inputs are driven and outputs sampled 1 ns after the falling edge.
  // This stays clear of the active rising edge.
  task automatic tick();
    @(negedge ACLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compCount++;
    assert (observed === expected)
    else begin
      errCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Raise start with the given operands and tick until o_busy drops.
  // Returns how many sampled cycles were busy, and which cycle carried the
  // strobe. Cycle 1 is the first sample after the start edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input bit pulse, input bit changeR0,
                               output int busyCycles, output int strobeAt);
    bit finished;
    busyCycles = 0;
    strobeAt   = 0;
    finished   = 1'b0;
    i_r0       = a;
    i_r1       = b;
    i_start    = 1'b1;
    for (int cyc = 1; cyc <= 80 && !finished; cyc++) begin
      tick();
      if (pulse) i_start = 1'b0;
      if (changeR0) i_r0 = 32'h0;
      if (o_enable_ctrl_write) strobeAt = cyc;
      if (o_busy) busyCycles++;
      else finished = 1'b1;
    end
    if (!finished) timeouts++;
  endtask

  initial begin
    int busyCycles;
    int strobeAt;
    int s0;
    int extraBusy;
    logic [31:0] swA [3];
    logic [31:0] swB [3];
    logic [32:0] refSum;
    int b32, b1;
    logic [31:0] r32, r1;
    bit swDone;

    ARSTn   = 1'b0;
    i_start = 1'b0;
    i_r0    = '0;
    i_r1    = '0;
    swStart = 1'b0;
    swR0    = '0;
    swR1    = '0;

    // Reset state
    tick();
    checkOutput("rst_busr",  o_busr, 32'h0);
    checkOutput("rst_wr",    32'(o_enable_ctrl_write), 32'h0);
    checkOutput("rst_carry", 32'(o_carry), 32'h0);
    checkOutput("rst_busy",  32'(o_busy), 32'h0);
    checkOutput("rst_done",  32'(o_done), 32'h0);
    ARSTn = 1'b1;
    tick();

    // Basic add: 0xAAAA + 0xBBBB, start pulsed for one cycle
    s0 = strobeTotal;
    applyStimulus(32'h0000AAAA, 32'h0000BBBB, 1'b1, 1'b0, busyCycles, strobeAt);
    checkOutput("basic_busy",    32'(busyCycles), 32'd5);
    checkOutput("basic_latency", 32'(strobeAt), 32'd5);
    checkOutput("basic_strobes", 32'(strobeTotal - s0), 32'd1);
    checkOutput("basic_sum",     lastResult, 32'h00016665);
    checkOutput("basic_carry",   32'(o_carry), 32'h0);

    // Overflow: carry ripples through every slice
    applyStimulus(32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, busyCycles, strobeAt);
    checkOutput("ovf_sum",   lastResult, 32'h00000000);
    checkOutput("ovf_carry", 32'(o_carry), 32'h1);
    tick();
    tick();
    checkOutput("ovf_carry_held", 32'(o_carry), 32'h1);

    // Operand stability: R0 is cleared right after the start edge
    applyStimulus(32'h12345678, 32'h11111111, 1'b1, 1'b1, busyCycles, strobeAt);
    checkOutput("stable_sum",   lastResult, 32'h23456789);
    checkOutput("stable_carry", 32'(o_carry), 32'h0);

    // Start held high for 20 cycles: exactly one operation
    s0 = strobeTotal;
    applyStimulus(32'h00000003, 32'h00000004, 1'b0, 1'b0, busyCycles, strobeAt);
    extraBusy = 0;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (o_busy) extraBusy++;
    end
    checkOutput("hold_strobes", 32'(strobeTotal - s0), 32'd1);
    checkOutput("hold_sum",     lastResult, 32'h00000007);
    checkOutput("hold_nobusy",  32'(extraBusy), 32'd0);
    i_start = 1'b0;
    tick();

    // A second start edge while busy is ignored
    s0 = strobeTotal;
    busyCycles = 0;
    i_r0 = 32'h00000100;
    i_r1 = 32'h00000200;
    i_start = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k == 0) i_start = 1'b0;
      if (k == 1) i_start = 1'b1;
      if (k == 2) i_start = 1'b0;
      if (o_busy) busyCycles++;
    end
    checkOutput("busyedge_busy",    32'(busyCycles), 32'd5);
    checkOutput("busyedge_strobes", 32'(strobeTotal - s0), 32'd1);
    checkOutput("busyedge_sum",     lastResult, 32'h00000300);

    // Fresh low-to-high after completion triggers again
    s0 = strobeTotal;
    applyStimulus(32'h00000010, 32'h00000020, 1'b1, 1'b0, busyCycles, strobeAt);
    checkOutput("retrig_strobes", 32'(strobeTotal - s0), 32'd1);
    checkOutput("retrig_sum",     lastResult, 32'h00000030);

    // Reset in the middle of ADD: outputs clear at once, no strobe
    s0 = strobeTotal;
    i_r0 = 32'hFFFFFFFF;
    i_r1 = 32'hFFFFFFFF;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    ARSTn = 1'b0;
    #1;
    checkOutput("midrst_busy",  32'(o_busy), 32'h0);
    checkOutput("midrst_wr",    32'(o_enable_ctrl_write), 32'h0);
    checkOutput("midrst_busr",  o_busr, 32'h0);
    checkOutput("midrst_done",  32'(o_done), 32'h0);
    checkOutput("midrst_carry", 32'(o_carry), 32'h0);
    tick();
    tick();
    ARSTn = 1'b1;
    tick();
    tick();
    checkOutput("midrst_nostrobe", 32'(strobeTotal - s0), 32'd0);
    applyStimulus(32'h00000001, 32'h00000002, 1'b1, 1'b0, busyCycles, strobeAt);
    checkOutput("postrst_busy", 32'(busyCycles), 32'd5);
    checkOutput("postrst_sum",  lastResult, 32'h00000003);

    // Lane-width extremes on directed and random operands
    swA[0] = 32'hFFFFFFFF; swB[0] = 32'h00000001;
    swA[1] = $urandom;     swB[1] = $urandom;
    swA[2] = $urandom;     swB[2] = $urandom;
    for (int v = 0; v < 3; v++) begin
      refSum = {1'b0, swA[v]} + {1'b0, swB[v]};
      swR0 = swA[v];
      swR1 = swB[v];
      swStart = 1'b1;
      b32 = 0;
      b1  = 0;
      r32 = 32'hDEADBEEF;
      r1  = 32'hDEADBEEF;
      swDone = 1'b0;
      for (int cyc = 1; cyc <= 80 && !swDone; cyc++) begin
        tick();
        swStart = 1'b0;
        if (busy32) b32++;
        if (busy1) b1++;
        if (en32) r32 = busr32;
        if (en1) r1 = busr1;
        if (!busy32 && !busy1) swDone = 1'b1;
      end
      if (!swDone) timeouts++;
      checkOutput($sformatf("sweep%0d_busy_n1", v),   32'(b32), 32'd2);
      checkOutput($sformatf("sweep%0d_busy_n32", v),  32'(b1), 32'd33);
      checkOutput($sformatf("sweep%0d_sum_n1", v),    r32, refSum[31:0]);
      checkOutput($sformatf("sweep%0d_sum_n32", v),   r1, refSum[31:0]);
      checkOutput($sformatf("sweep%0d_carry_n1", v),  32'(carry32), 32'(refSum[32]));
      checkOutput($sformatf("sweep%0d_carry_n32", v), 32'(carry1), 32'(refSum[32]));
      tick();
    end

    checkOutput("stale_busr", 32'(staleCount), 32'd0);
    checkOutput("done_align", 32'(doneSkew), 32'd0);
    checkOutput("timeouts",   32'(timeouts), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
    $finish;
  end

endmodule
